sha256_scheduler: RTL
=====================

SHA256_SCHEDULER -- requirements
Module: sha256_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester streams sharing one SHA-256 core; legal range 2..8.
REQ-002 Localparam IDW = $clog2(NUM_REQ), requester index width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 req_tdata  input  NUM_REQ*32  requester message words; slice i = bits [32*i+31:32*i].
REQ-006 req_tvalid / req_tlast  input  NUM_REQ each  per-requester AXIS valid / last-word-of-message.
REQ-007 req_tready  output  NUM_REQ  per-requester ready.
REQ-008 core_s_tdata/tvalid/tlast  output  32/1/1  message stream into the core.
REQ-009 core_s_tready  input  1  core input ready.
REQ-010 core_m_tdata/tvalid/tlast  input  32/1/1  digest stream from the core, 8 words.
REQ-011 core_m_tready  output  1  digest ready to the core.
REQ-012 res_tdata/tvalid/tlast  output  32/1/1  digest stream to consumers.
REQ-013 res_tdest  output  IDW  requester index owning the current digest.
REQ-014 res_tready  input  1  consumer ready.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 States: IDLE, FORWARD, WAIT_RESULT; state, grant and last_grant are registered.
REQ-017 IDLE: if any req_tvalid is high, grant = first set bit searching circularly from last_grant+1; next cycle state = FORWARD.
REQ-018 IDLE with no req_tvalid: remain in IDLE; grant unchanged.
REQ-019 FORWARD: core_s_tdata/tvalid/tlast = slice grant of req inputs; req_tready[grant] = core_s_tready; all other req_tready = 0.
REQ-020 FORWARD: grant is held for the whole message regardless of req_tvalid gaps from the granted requester.
REQ-021 FORWARD: handshake (core_s_tvalid & core_s_tready & core_s_tlast) -> WAIT_RESULT next cycle.
REQ-022 Outside FORWARD: core_s_tvalid = 0 and all req_tready = 0.
REQ-023 WAIT_RESULT: res_tdata/tvalid/tlast = core_m_*; core_m_tready = res_tready; res_tdest = grant.
REQ-024 Outside WAIT_RESULT: res_tvalid = 0 and core_m_tready = 0.
REQ-025 WAIT_RESULT: handshake (res_tvalid & res_tready & res_tlast) -> IDLE next cycle; last_grant <= grant.
REQ-026 A requester asserting tvalid while another is granted waits; arbitration happens only in IDLE.
REQ-027 Requester ordering: requester k is served at most once per NUM_REQ messages while the others have pending requests (no starvation).
REQ-028 Latency: first core_s word may be accepted one cycle after req_tvalid is seen in IDLE.
REQ-029 Data paths are combinational pass-through; no word buffering or reordering.

Reset
REQ-030 On resetn low: state = IDLE, grant = 0, last_grant = NUM_REQ-1 (requester 0 wins first), busy = 0, all tvalid/tready outputs = 0.
REQ-031 Reset mid-message discards the transfer; the core shares resetn and restarts with it.

Configuration
REQ-032 Macro SHA256_SCHED_STATS_EN defined: output msg_count [NUM_REQ*16] adds one 16-bit counter per requester, incremented on the REQ-025 handshake, saturating at 16'hFFFF, reset to 0.
REQ-033 Macro undefined: msg_count port and counters absent; all other behaviour identical.

Structure
REQ-034 sha256_pkg holds the scheduler state enum typedef and constant SHA256_DIGEST_WORDS = 8.
REQ-035 Sub-module sha256_rr_arbiter: combinational round-robin pick (request vector, last_grant -> grant, any_req).

Verification
REQ-036 Single requester 2, 16-word message "abc" padded -> res_tdest=2, 8 words ending 0xF20015AD with res_tlast, busy returns 0.
REQ-037 All four requesters valid from reset -> grant order 0,1,2,3,0; each res_tdest matches the message owner.
REQ-038 Requester 1 granted, drops tvalid for 5 cycles mid-message while requester 3 valid -> grant stays 1; req_tready[3]=0 throughout.
REQ-039 res_tready held low 10 cycles in WAIT_RESULT -> core_m_tready=0, res_tdata stable, no word lost.
REQ-040 resetn pulsed low during FORWARD word 7 -> all outputs idle next edge; next message granted to requester 0.
REQ-041 With SHA256_SCHED_STATS_EN, 3 messages from requester 0 -> msg_count[15:0]=3, others 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 request scheduler.
// Holds the scheduler state encoding and digest length.
package sha256_pkg;

    localparam int SHA256_DIGEST_WORDS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FORWARD,
        ST_WAIT_RESULT
    } sched_state_t;

endpackage

// File: rtl/sha256_rr_arbiter.sv
// Combinational round-robin pick among requesters.
// Search starts one position after the previous winner.
module sha256_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     grant,
    output logic               any_req
);

    logic [IDW-1:0] idx;

    // walk the ring from last_grant+1 and keep the first active request
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last_grant) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_scheduler.sv
// Shares one SHA-256 core among NUM_REQ AXIS message streams.
// Define SHA256_SCHED_STATS_EN to add per-requester message counters.
module sha256_scheduler
    import sha256_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ*32-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]    req_tvalid,
    input  logic [NUM_REQ-1:0]    req_tlast,
    output logic [NUM_REQ-1:0]    req_tready,
    output logic [31:0]           core_s_tdata,
    output logic                  core_s_tvalid,
    output logic                  core_s_tlast,
    input  logic                  core_s_tready,
    input  logic [31:0]           core_m_tdata,
    input  logic                  core_m_tvalid,
    input  logic                  core_m_tlast,
    output logic                  core_m_tready,
    output logic [31:0]           res_tdata,
    output logic                  res_tvalid,
    output logic                  res_tlast,
    output logic [IDW-1:0]        res_tdest,
    input  logic                  res_tready,
    output logic                  busy
`ifdef SHA256_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] msg_count
`endif
);

    sched_state_t   state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] arb_grant;
    logic           arb_any;
    logic           in_fwd;
    logic           in_wait;
    logic           sel_valid;
    logic           sel_last;
    logic [31:0]    sel_data;
    logic           msg_done;
    logic           res_done;

    sha256_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req       (req_tvalid),
        .last_grant(last_grant),
        .grant     (arb_grant),
        .any_req   (arb_any)
    );

    assign in_fwd  = (state == ST_FORWARD);
    assign in_wait = (state == ST_WAIT_RESULT);

    // select the granted requester's lane
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_data  = req_tdata[32*i +: 32];
                sel_valid = req_tvalid[i];
                sel_last  = req_tlast[i];
            end
        end
    end

    assign core_s_tdata  = sel_data;
    assign core_s_tvalid = in_fwd & sel_valid;
    assign core_s_tlast  = in_fwd & sel_last;
    assign req_tready    = in_fwd ? (NUM_REQ'(core_s_tready) << grant)
                                  : '0;

    assign res_tdata     = core_m_tdata;
    assign res_tvalid    = in_wait & core_m_tvalid;
    assign res_tlast     = in_wait & core_m_tlast;
    assign res_tdest     = grant;
    assign core_m_tready = in_wait & res_tready;

    assign msg_done = core_s_tvalid & core_s_tready & core_s_tlast;
    assign res_done = res_tvalid & res_tready & res_tlast;

    // arbitrate in idle, hold the grant through message and digest
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            busy       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant <= arb_grant;
                        state <= ST_FORWARD;
                        busy  <= 1'b1;
                    end
                end
                ST_FORWARD: begin
                    if (msg_done) begin
                        state <= ST_WAIT_RESULT;
                    end
                end
                ST_WAIT_RESULT: begin
                    if (res_done) begin
                        state      <= ST_IDLE;
                        last_grant <= grant;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA256_SCHED_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt;

        // count digests delivered to this requester, stick at all-ones
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt <= '0;
            end else if (res_done && grant == IDW'(g)
                         && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign msg_count[16*g +: 16] = cnt;
    end
`endif

endmodule
